// File: rtl/fifo_sync_param_if.sv
// fifo_sync_param_if: write/read handshake, status and error bundle of fifo_sync_param.
// master = producer/consumer side, slave = FIFO side.
interface fifo_sync_param_if #(
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic                  underflow;
    logic                  clr_err;

    modport master (
        output wr_en, wr_data, rd_en, clr_err,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en, clr_err,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parametrised single-clock FIFO with thresholds, count and sticky errors; FIFO_FWFT_EN selects first-word-fall-through.
// Latency: rd_data/rd_valid one cycle after an accepted read; in FWFT mode the head appears one cycle after its write.
// Backpressure: writes while full / reads while empty are dropped and latch overflow/underflow until clr_err.
module fifo_sync_param #(
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input logic              clk,
    input logic              rst,
    fifo_sync_param_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]         wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
    logic [CW-1:0]         count_q, count_nxt;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_nxt;
    logic                  rd_valid_q, rd_valid_nxt;
    logic                  full_q, empty_q, af_q, ae_q;
    logic                  ovf_q, unf_q;
    logic                  wr_acc, rd_acc;

    // Acceptance uses the registered flags, i.e. the state before this edge.
    // In FWFT mode empty_q always equals !rd_valid_q, so one rule covers both modes.
    assign wr_acc     = bus.wr_en && !full_q;
    assign rd_acc     = bus.rd_en && !empty_q;
    assign rd_ptr_nxt = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;

    always_comb begin
        count_nxt = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count_q + CW'(1);
            2'b01:   count_nxt = count_q - CW'(1);
            default: count_nxt = count_q;
        endcase
    end

    always_comb begin
        rd_data_nxt  = rd_data_q;
        rd_valid_nxt = 1'b0;
`ifdef FIFO_FWFT_EN
        rd_valid_nxt = (count_nxt != '0);
        // The new head bypasses memory when it is the word being written this edge.
        if (wr_acc && ((count_q == '0) || ((count_q == CW'(1)) && rd_acc)))
            rd_data_nxt = bus.wr_data;
        else if (rd_acc && (count_nxt != '0))
            rd_data_nxt = mem[rd_ptr_nxt];
`else
        rd_valid_nxt = rd_acc;
        if (rd_acc)
            rd_data_nxt = mem[rd_ptr_q];
`endif
    end

    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr_q] <= bus.wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            af_q       <= 1'b0;
            ae_q       <= 1'b1;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            if (wr_acc)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            rd_ptr_q   <= rd_ptr_nxt;
            count_q    <= count_nxt;
            rd_data_q  <= rd_data_nxt;
            rd_valid_q <= rd_valid_nxt;
            full_q     <= (count_nxt == DEPTH_C);
            empty_q    <= (count_nxt == '0);
            af_q       <= (count_nxt >= AF_C);
            ae_q       <= (count_nxt <= AE_C);
            // A new error in the same cycle as clr_err wins.
            ovf_q      <= (bus.wr_en && full_q) || (ovf_q && !bus.clr_err);
            unf_q      <= (bus.rd_en && empty_q) || (unf_q && !bus.clr_err);
        end
    end

    assign bus.rd_data      = rd_data_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.count        = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;
endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
- Parametrised single-clock FIFO; next generation of the fixed 128-bit FIFO on the FIFO_in bus.
- Generalises data width and depth.
- Adds programmable almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow flags, a read-valid strobe and an optional first-word-fall-through mode.
- Sits between the AXI write-data path and downstream consumers; pin-compatible with the FIFO_in agent when DATA_WIDTH=128.

Parameters:
- DATA_WIDTH, 128, width of wr_data/rd_data in bits (>=1).
- DEPTH, 16, number of storage entries; power of two, >=2.
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH.
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH.
- CW, $clog2(DEPTH+1), derived width of count; not overridable.

Ports:
- clk  input  1  clock, all logic rising-edge.
- rst  input  1  reset, asynchronous assert, active-low (0 = reset), synchronous deassert handled by the caller.
- wr_en  input  1  write request.
- wr_data  input  DATA_WIDTH  write data.
- rd_en  input  1  read request (standard mode) / pop (FWFT mode).
- rd_data  output  DATA_WIDTH  read data, registered.
- rd_valid  output  1  rd_data holds a valid popped word.
- full  output  1  no free entry.
- empty  output  1  no readable entry.
- almost_full  output  1  count >= AF_THRESH.
- almost_empty  output  1  count <= AE_THRESH.
- count  output  CW  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: write attempted while full.
- underflow  output  1  sticky: read attempted while empty.
- clr_err  input  1  synchronous clear of overflow/underflow.

Behaviour:
- Reset (rst=0, async):
  - Pointers and count go to 0; rd_data=0, rd_valid=0.
  - full=0, empty=1, almost_full=0, almost_empty=1.
  - overflow=0, underflow=0.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored words; no partial transfer completes.
- Write accepted iff wr_en=1 and full=0. The word is stored at wr_ptr, and wr_ptr increments modulo DEPTH (natural wrap, power-of-two).
- Read accepted iff rd_en=1 and empty=0. rd_ptr increments modulo DEPTH.
- Standard mode latency: rd_data and rd_valid update one cycle after the accepted read. rd_valid=1 for exactly one cycle per accepted read; rd_data holds its last value otherwise.
- Flags:
  - full, empty, almost_* and count are all registered and reflect state after the current edge.
  - full = (count==DEPTH); empty = (count==0).
- Count update per cycle:
  - +1 on write only
  - −1 on read only
  - unchanged on simultaneous accepted read and write, or on no access.
- Simultaneous write and read while full: the read is accepted. The write is rejected and sets overflow, because full is sampled before the edge.
- Simultaneous write and read while empty: the write is accepted. The read is rejected and sets underflow.
- Rejected accesses change no pointer, no data and no count.
- overflow/underflow set on the cycle after the offending request and stay set until clr_err=1. If clr_err and a new error occur in the same cycle, the flag stays set.
- Pointer wrap: write DEPTH words, read DEPTH words, then repeat. Data order is preserved across the wrap with no bubble.

Optional Feature:
- Macro: FIFO_FWFT_EN.
- Defined (first-word-fall-through mode):
  - The head word is presented on rd_data with rd_valid=1 whenever the FIFO is non-empty, without rd_en.
  - A write into an empty FIFO appears on rd_data one cycle after the write edge.
  - rd_en=1 with rd_valid=1 pops the head; the next word, if any, is presented on the following cycle with no gap.
  - empty = !rd_valid. count includes the presented word.
  - rd_en with rd_valid=0 sets underflow.
- Undefined: standard mode as described above.
- Port list is identical in both modes.

Test Plan:
- Reset with rst=0 for 3 cycles, then release -> empty=1, full=0, count=0, almost_empty=1, rd_valid=0, overflow=underflow=0.
- DEPTH=16: write 0x0..0xF, 16 cycles -> count reaches 16, full=1 on the cycle after the 16th write, almost_full=1 from count=14. A 17th write sets overflow=1 and count stays 16.
- Read all 16 words in standard mode -> rd_data = 0x0..0xF in order, each with a one-cycle rd_valid pulse one cycle after rd_en. empty=1 after the last read. A further rd_en sets underflow=1.
- Pre-fill 8 words, then drive wr_en=rd_en=1 for 40 cycles with incrementing data -> count holds 8, data order is preserved across 2+ pointer wraps, no error flags set.
- Full FIFO with simultaneous wr_en=rd_en=1 -> read returns the oldest word, count=15, overflow=1. Then clr_err=1 for 1 cycle -> overflow=0.
- FIFO_FWFT_EN defined: single write of 0xA5 into an empty FIFO -> rd_valid=1 and rd_data=0xA5 one cycle later with no rd_en. rd_en=1 for one cycle -> rd_valid=0, empty=1, count=0.
